// File: rtl/hazard_scheduler_pkg.sv
// Shared constants for the hazard scheduler: forwarding-select encoding,
// register-file address conventions and the forwarding priority helper.
package hazard_scheduler_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  // EXE operand source selects; 2'b11 is reserved and never driven.
  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_REGS = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  localparam logic RST_ENABLE     = 1'b1;
  localparam logic WRT_ENABLE     = 1'b1;
  localparam logic RD_ENABLE      = 1'b1;
  localparam int unsigned ZERO_REG_ADDR = 0;

  // Youngest producer wins. A producer in WB is covered by the write-through
  // register file, so it resolves to the register-file path like no match.
  function automatic fwd_sel_e fwd_pick(input logic exe_match,
                                        input logic mem_match,
                                        input logic wb_match);
    fwd_sel_e sel;
    sel = FWD_REGS;
    if (exe_match)      sel = FWD_MEM;
    else if (mem_match) sel = FWD_WB;
    else if (wb_match)  sel = FWD_REGS;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// Decode-side hazard interface: issue request from ID and the stall /
// forwarding / statistics outputs back to the pipeline.
interface hazard_scheduler_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  import hazard_scheduler_pkg::*;

  logic                 Issue_Valid_i_Hzd;
  logic                 RdEn_1_i_Hzd;
  logic [ADDR_W-1:0]    Rd_Addr1_i_Hzd;
  logic                 RdEn_2_i_Hzd;
  logic [ADDR_W-1:0]    Rd_Addr2_i_Hzd;
  logic                 WrEn_i_Hzd;
  logic [ADDR_W-1:0]    WrAddr_i_Hzd;
  logic                 IsLoad_i_Hzd;
  logic                 Flush_i_Hzd;
  logic                 Stall_o_Hzd;
  logic [FWD_SEL_W-1:0] Fwd1_Sel_o_Hzd;
  logic [FWD_SEL_W-1:0] Fwd2_Sel_o_Hzd;
  logic [CNT_W-1:0]     StallCnt_o_Hzd;

  modport master (
    output Issue_Valid_i_Hzd, RdEn_1_i_Hzd, Rd_Addr1_i_Hzd, RdEn_2_i_Hzd,
           Rd_Addr2_i_Hzd, WrEn_i_Hzd, WrAddr_i_Hzd, IsLoad_i_Hzd, Flush_i_Hzd,
    input  Stall_o_Hzd, Fwd1_Sel_o_Hzd, Fwd2_Sel_o_Hzd, StallCnt_o_Hzd
  );

  modport slave (
    input  Issue_Valid_i_Hzd, RdEn_1_i_Hzd, Rd_Addr1_i_Hzd, RdEn_2_i_Hzd,
           Rd_Addr2_i_Hzd, WrEn_i_Hzd, WrAddr_i_Hzd, IsLoad_i_Hzd, Flush_i_Hzd,
    output Stall_o_Hzd, Fwd1_Sel_o_Hzd, Fwd2_Sel_o_Hzd, StallCnt_o_Hzd
  );

endinterface

// File: rtl/hazard_scheduler_match.sv
// Single scoreboard-slot versus source-operand comparator. x0 and disabled
// reads never match.
module hazard_match #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              slot_valid,
  input  logic [ADDR_W-1:0] slot_waddr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              match
);

  assign match = slot_valid && rd_en && (rd_addr != '0) && (slot_waddr == rd_addr);

endmodule

// File: rtl/hazard_scheduler.sv
// Load-use stall and ID_EXE forwarding-select generation from a 3-stage
// destination scoreboard (EXE, MEM, WB).
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic clk_i_Hzd,
  input logic Rst_i_Hzd,
  hazard_scheduler_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] waddr;
    logic              is_load;
  } slot_t;

  slot_t            slot_exe, slot_mem, slot_wb;
  fwd_sel_e         sel1, sel2;
  logic [CNT_W-1:0] stall_cnt;

  logic exe_m1, exe_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic stall, accept;
  logic unused;

  hazard_match #(.ADDR_W(ADDR_W)) u_exe_op1 (
    .slot_valid(slot_exe.valid), .slot_waddr(slot_exe.waddr),
    .rd_en(hz.RdEn_1_i_Hzd), .rd_addr(hz.Rd_Addr1_i_Hzd), .match(exe_m1));
  hazard_match #(.ADDR_W(ADDR_W)) u_exe_op2 (
    .slot_valid(slot_exe.valid), .slot_waddr(slot_exe.waddr),
    .rd_en(hz.RdEn_2_i_Hzd), .rd_addr(hz.Rd_Addr2_i_Hzd), .match(exe_m2));
  hazard_match #(.ADDR_W(ADDR_W)) u_mem_op1 (
    .slot_valid(slot_mem.valid), .slot_waddr(slot_mem.waddr),
    .rd_en(hz.RdEn_1_i_Hzd), .rd_addr(hz.Rd_Addr1_i_Hzd), .match(mem_m1));
  hazard_match #(.ADDR_W(ADDR_W)) u_mem_op2 (
    .slot_valid(slot_mem.valid), .slot_waddr(slot_mem.waddr),
    .rd_en(hz.RdEn_2_i_Hzd), .rd_addr(hz.Rd_Addr2_i_Hzd), .match(mem_m2));
  hazard_match #(.ADDR_W(ADDR_W)) u_wb_op1 (
    .slot_valid(slot_wb.valid), .slot_waddr(slot_wb.waddr),
    .rd_en(hz.RdEn_1_i_Hzd), .rd_addr(hz.Rd_Addr1_i_Hzd), .match(wb_m1));
  hazard_match #(.ADDR_W(ADDR_W)) u_wb_op2 (
    .slot_valid(slot_wb.valid), .slot_waddr(slot_wb.waddr),
    .rd_en(hz.RdEn_2_i_Hzd), .rd_addr(hz.Rd_Addr2_i_Hzd), .match(wb_m2));

  // A load in EXE cannot forward yet; a flush overrides the stall since ID dies.
  always_comb begin
    stall  = hz.Issue_Valid_i_Hzd && !hz.Flush_i_Hzd && slot_exe.is_load &&
             (exe_m1 || exe_m2);
    accept = hz.Issue_Valid_i_Hzd && !stall && !hz.Flush_i_Hzd;
  end

  // The WB slot's load flag has no consumer once the producer reaches WB.
  assign unused = slot_wb.is_load;

  // Scoreboard shift, forwarding selects for the next EXE cycle, stall count.
  always_ff @(posedge clk_i_Hzd) begin
    if (Rst_i_Hzd == RST_ENABLE) begin
      slot_exe  <= '0;
      slot_mem  <= '0;
      slot_wb   <= '0;
      sel1      <= FWD_REGS;
      sel2      <= FWD_REGS;
      stall_cnt <= '0;
    end else begin
      slot_wb  <= slot_mem;
      slot_mem <= slot_exe;
      if (accept) begin
        slot_exe.valid   <= hz.WrEn_i_Hzd && (hz.WrAddr_i_Hzd != '0);
        slot_exe.waddr   <= hz.WrAddr_i_Hzd;
        slot_exe.is_load <= hz.IsLoad_i_Hzd;
        sel1             <= fwd_pick(exe_m1, mem_m1, wb_m1);
        sel2             <= fwd_pick(exe_m2, mem_m2, wb_m2);
      end else begin
        slot_exe <= '0;
        sel1     <= FWD_REGS;
        sel2     <= FWD_REGS;
      end
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.Stall_o_Hzd    = stall;
  assign hz.Fwd1_Sel_o_Hzd = sel1;
  assign hz.Fwd2_Sel_o_Hzd = sel2;
  assign hz.StallCnt_o_Hzd = stall_cnt;

endmodule
